// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings and the execute bundle layout for the decode stage.
package mips_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned NREGS  = 32;
   localparam int unsigned RIDX_W = 5;
   localparam int unsigned OP_W   = 6;
   localparam int unsigned SA_W   = 5;

   // primary opcodes
   localparam logic [OP_W-1:0] RTYPE  = 6'b000000;
   localparam logic [OP_W-1:0] REGIMM = 6'b000001;
   localparam logic [OP_W-1:0] J_OP   = 6'b000010;
   localparam logic [OP_W-1:0] JAL_OP = 6'b000011;
   localparam logic [OP_W-1:0] BEQ    = 6'b000100;
   localparam logic [OP_W-1:0] BNE    = 6'b000101;
   localparam logic [OP_W-1:0] BLEZ   = 6'b000110;
   localparam logic [OP_W-1:0] BGTZ   = 6'b000111;
   localparam logic [OP_W-1:0] ADDI   = 6'b001000;
   localparam logic [OP_W-1:0] ADDIU  = 6'b001001;
   localparam logic [OP_W-1:0] SLTI   = 6'b001010;
   localparam logic [OP_W-1:0] SLTIU  = 6'b001011;
   localparam logic [OP_W-1:0] ANDI   = 6'b001100;
   localparam logic [OP_W-1:0] ORI    = 6'b001101;
   localparam logic [OP_W-1:0] XORI   = 6'b001110;
   localparam logic [OP_W-1:0] LUI    = 6'b001111;
   localparam logic [OP_W-1:0] MUL_OP = 6'b011100;
   localparam logic [OP_W-1:0] LB     = 6'b100000;
   localparam logic [OP_W-1:0] LW     = 6'b100011;
   localparam logic [OP_W-1:0] LBU    = 6'b100100;
   localparam logic [OP_W-1:0] SB     = 6'b101000;
   localparam logic [OP_W-1:0] SW     = 6'b101011;

   // R-type function codes that change dest/regwrite
   localparam logic [OP_W-1:0] F_JR   = 6'b001000;

   localparam logic [RIDX_W-1:0] REG_RA = 5'd31;

   // execute bundle held in the pipeline register
   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   insn;
      logic [XLEN-1:0]   rs_data;
      logic [XLEN-1:0]   rt_data;
      logic [SA_W-1:0]   sa;
      logic [XLEN-1:0]   imm;
      logic [OP_W-1:0]   alu_op;
      logic [RIDX_W-1:0] dest;
      logic              regwrite;
   } ex_bundle_t;

endpackage

// File: rtl/mips_regfile.sv
// Architectural register file: r0 reads zero, two async read ports with writeback bypass.
module mips_regfile
   import mips_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic [RIDX_W-1:0] rs_addr,
   input  logic [RIDX_W-1:0] rt_addr,
   output logic [XLEN-1:0]   rs_data_c,
   output logic [XLEN-1:0]   rt_data_c,
   input  logic              wb_en,
   input  logic [RIDX_W-1:0] wb_addr,
   input  logic [XLEN-1:0]   wb_data
);

   logic [XLEN-1:0] regs [NREGS];

   // write port; r0 is never written so it stays zero
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wb_en && wb_addr != '0) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // read ports with same-cycle writeback forwarding
   always_comb begin
      rs_data_c = '0;
      rt_data_c = '0;
      if (rs_addr != '0)
         rs_data_c = (wb_en && wb_addr == rs_addr) ? wb_data : regs[rs_addr];
      if (rt_addr != '0)
         rt_data_c = (wb_en && wb_addr == rt_addr) ? wb_data : regs[rt_addr];
   end

endmodule

// File: rtl/mips_decode_stage.sv
// Decode stage: register read, immediate/ALUOp/dest decode, one-entry handshake register.
module mips_decode_stage
   import mips_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              fd_valid,
   input  logic [XLEN-1:0]   fd_pc,
   input  logic [XLEN-1:0]   fd_insn,
   output logic              fd_ready,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_insn,
   output logic [XLEN-1:0]   ex_rsData,
   output logic [XLEN-1:0]   ex_rtData,
   output logic [SA_W-1:0]   ex_saData,
   output logic [XLEN-1:0]   ex_immSXData,
   output logic [OP_W-1:0]   ex_ALUOp,
   output logic [RIDX_W-1:0] ex_dest,
   output logic              ex_regwrite,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [RIDX_W-1:0] wb_addr,
   input  logic [XLEN-1:0]   wb_data
);

   ex_bundle_t        ex_q;
   ex_bundle_t        dec_c;
   logic              valid_q;
   logic [XLEN-1:0]   rs_data_c;
   logic [XLEN-1:0]   rt_data_c;
   logic [OP_W-1:0]   opcode_c;
   logic [OP_W-1:0]   funct_c;

   mips_regfile u_regfile (
      .clock     (clock),
      .reset_n   (reset_n),
      .rs_addr   (fd_insn[25:21]),
      .rt_addr   (fd_insn[20:16]),
      .rs_data_c (rs_data_c),
      .rt_data_c (rt_data_c),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data)
   );

   // a free or draining register can take a new instruction
   assign fd_ready = !valid_q || ex_ready;

   // combinational decode of the presented instruction
   always_comb begin
      dec_c          = '0;
      opcode_c       = fd_insn[31:26];
      funct_c        = fd_insn[5:0];
      dec_c.pc       = fd_pc;
      dec_c.insn     = fd_insn;
      dec_c.rs_data  = rs_data_c;
      dec_c.rt_data  = rt_data_c;
      dec_c.sa       = fd_insn[10:6];
      dec_c.imm      = (opcode_c inside {ANDI, ORI, XORI}) ?
                       {16'h0000, fd_insn[15:0]} : {{16{fd_insn[15]}}, fd_insn[15:0]};
      dec_c.alu_op   = (opcode_c == RTYPE || opcode_c == MUL_OP) ? funct_c : opcode_c;
      case (opcode_c)
         RTYPE: begin
            if (funct_c != F_JR) begin
               dec_c.dest     = fd_insn[15:11];
               dec_c.regwrite = 1'b1;
            end
         end
         MUL_OP: begin
            dec_c.dest     = fd_insn[15:11];
            dec_c.regwrite = 1'b1;
         end
         JAL_OP: begin
            dec_c.dest     = REG_RA;
            dec_c.regwrite = 1'b1;
         end
         ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI, LW, LB, LBU: begin
            dec_c.dest     = fd_insn[20:16];
            dec_c.regwrite = 1'b1;
         end
         BEQ, BNE, BLEZ, BGTZ, REGIMM, J_OP, SW, SB: dec_c.regwrite = 1'b0;
         default: dec_c.regwrite = 1'b0;
      endcase
   end

   // pipeline register: flush wins, then accept, else hold with operand refresh
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         ex_q    <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (fd_ready) begin
         valid_q <= fd_valid;
         if (fd_valid) ex_q <= dec_c;
      end else begin
         if (wb_en && wb_addr != '0 && wb_addr == ex_q.insn[25:21]) ex_q.rs_data <= wb_data;
         if (wb_en && wb_addr != '0 && wb_addr == ex_q.insn[20:16]) ex_q.rt_data <= wb_data;
      end
   end

   assign ex_valid     = valid_q;
   assign ex_pc        = ex_q.pc;
   assign ex_insn      = ex_q.insn;
   assign ex_rsData    = ex_q.rs_data;
   assign ex_rtData    = ex_q.rt_data;
   assign ex_saData    = ex_q.sa;
   assign ex_immSXData = ex_q.imm;
   assign ex_ALUOp     = ex_q.alu_op;
   assign ex_dest      = ex_q.dest;
   assign ex_regwrite  = ex_q.regwrite;

endmodule

// File: tb/tb_mips_decode_stage.sv
// Bench for mips_decode_stage: directed scenarios plus random traffic against a reference model.
module tb_mips_decode_stage;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        fd_valid;
   logic [31:0] fd_pc;
   logic [31:0] fd_insn;
   logic        fd_ready;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_pc;
   logic [31:0] ex_insn;
   logic [31:0] ex_rsData;
   logic [31:0] ex_rtData;
   logic [4:0]  ex_saData;
   logic [31:0] ex_immSXData;
   logic [5:0]  ex_ALUOp;
   logic [4:0]  ex_dest;
   logic        ex_regwrite;
   logic        flush;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [4:0]  sa;
      logic [31:0] imm;
      logic [5:0]  alu;
      logic [4:0]  dest;
      logic        rw;
   } mb_t;

   mb_t         m;
   logic        m_valid;
   logic [31:0] m_regs [32];

   localparam logic [5:0] OPS [0:25] = '{6'h00, 6'h00, 6'h00, 6'h1c, 6'h02, 6'h03, 6'h04,
      6'h05, 6'h06, 6'h07, 6'h01, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
      6'h20, 6'h23, 6'h24, 6'h28, 6'h2b, 6'h3f, 6'h11};

   mips_decode_stage dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .fd_valid     (fd_valid),
      .fd_pc        (fd_pc),
      .fd_insn      (fd_insn),
      .fd_ready     (fd_ready),
      .ex_valid     (ex_valid),
      .ex_ready     (ex_ready),
      .ex_pc        (ex_pc),
      .ex_insn      (ex_insn),
      .ex_rsData    (ex_rsData),
      .ex_rtData    (ex_rtData),
      .ex_saData    (ex_saData),
      .ex_immSXData (ex_immSXData),
      .ex_ALUOp     (ex_ALUOp),
      .ex_dest      (ex_dest),
      .ex_regwrite  (ex_regwrite),
      .flush        (flush),
      .wb_en        (wb_en),
      .wb_addr      (wb_addr),
      .wb_data      (wb_data)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // register read as the architecture defines it, including same-cycle writeback
   function automatic logic [31:0] ref_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'h0;
      if (wb_en && wb_addr == idx) return wb_data;
      return m_regs[idx];
   endfunction

   function automatic mb_t ref_decode();
      mb_t b;
      logic [5:0] op;
      logic [5:0] fn;
      op     = fd_insn[31:26];
      fn     = fd_insn[5:0];
      b.pc   = fd_pc;
      b.insn = fd_insn;
      b.rs   = ref_read(fd_insn[25:21]);
      b.rt   = ref_read(fd_insn[20:16]);
      b.sa   = fd_insn[10:6];
      if (op == 6'h0c || op == 6'h0d || op == 6'h0e) b.imm = {16'h0, fd_insn[15:0]};
      else b.imm = {{16{fd_insn[15]}}, fd_insn[15:0]};
      b.alu  = (op == 6'h00 || op == 6'h1c) ? fn : op;
      b.dest = 5'd0;
      b.rw   = 1'b0;
      if (op == 6'h00) begin
         if (fn != 6'h08) begin b.dest = fd_insn[15:11]; b.rw = 1'b1; end
      end else if (op == 6'h1c) begin
         b.dest = fd_insn[15:11]; b.rw = 1'b1;
      end else if (op == 6'h03) begin
         b.dest = 5'd31; b.rw = 1'b1;
      end else if (op inside {6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
                              6'h23, 6'h20, 6'h24}) begin
         b.dest = fd_insn[20:16]; b.rw = 1'b1;
      end
      return b;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m       = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
   endtask

   // one clock of the reference pipeline using the currently driven inputs
   task automatic model_step();
      if (flush) m_valid = 1'b0;
      else if (!m_valid || ex_ready) begin
         if (fd_valid) begin m = ref_decode(); m_valid = 1'b1; end
         else m_valid = 1'b0;
      end else begin
         if (wb_en && wb_addr != 5'd0 && wb_addr == m.insn[25:21]) m.rs = wb_data;
         if (wb_en && wb_addr != 5'd0 && wb_addr == m.insn[20:16]) m.rt = wb_data;
      end
      if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
   endtask

   task automatic compare_all();
      chk("ex_valid", 32'(ex_valid), 32'(m_valid));
      if (m_valid) begin
         chk("ex_pc", ex_pc, m.pc);
         chk("ex_insn", ex_insn, m.insn);
         chk("ex_rsData", ex_rsData, m.rs);
         chk("ex_rtData", ex_rtData, m.rt);
         chk("ex_saData", 32'(ex_saData), 32'(m.sa));
         chk("ex_immSXData", ex_immSXData, m.imm);
         chk("ex_ALUOp", 32'(ex_ALUOp), 32'(m.alu));
         chk("ex_dest", 32'(ex_dest), 32'(m.dest));
         chk("ex_regwrite", 32'(ex_regwrite), 32'(m.rw));
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, 32'(ex_valid), 32'h0);
      chk({tag, "_fd_ready"}, 32'(fd_ready), 32'h1);
      chk({tag, "_pc"}, ex_pc, 32'h0);
      chk({tag, "_insn"}, ex_insn, 32'h0);
      chk({tag, "_rs"}, ex_rsData, 32'h0);
      chk({tag, "_rt"}, ex_rtData, 32'h0);
      chk({tag, "_sa"}, 32'(ex_saData), 32'h0);
      chk({tag, "_imm"}, ex_immSXData, 32'h0);
      chk({tag, "_alu"}, 32'(ex_ALUOp), 32'h0);
      chk({tag, "_dest"}, 32'(ex_dest), 32'h0);
      chk({tag, "_rw"}, 32'(ex_regwrite), 32'h0);
   endtask

   // drive one cycle of inputs, check the handshake, then check the registered result
   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic rdy, input logic fl, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd);
      @(negedge clock);
      fd_valid = v;  fd_pc = pc;   fd_insn = ins;
      ex_ready = rdy; flush = fl;
      wb_en = we;    wb_addr = wa; wb_data = wd;
      #1;
      chk("fd_ready", 32'(fd_ready), 32'(!m_valid || ex_ready));
      model_step();
      @(posedge clock);
      #1;
      compare_all();
   endtask

   task automatic wb(input logic [4:0] a, input logic [31:0] d);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, a, d);
   endtask

   localparam logic [31:0] ADD_3_1_2 = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
   localparam logic [31:0] ORI_4_1   = {6'h0d, 5'd1, 5'd4, 16'hFFFF};
   localparam logic [31:0] ADDI_4_1  = {6'h08, 5'd1, 5'd4, 16'hFFFF};
   localparam logic [31:0] ADD_3_0_0 = {6'h00, 5'd0, 5'd0, 5'd3, 5'd0, 6'h20};
   localparam logic [31:0] SW_2_1    = {6'h2b, 5'd1, 5'd2, 16'd4};
   localparam logic [31:0] JAL_T     = {6'h03, 26'h0000100};

   initial begin
      reset_n = 1'b0;
      fd_valid = 1'b0; fd_pc = '0; fd_insn = '0; ex_ready = 1'b0;
      flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      model_reset();
      #2;
      chk_zero("reset");
      @(negedge clock);
      reset_n = 1'b1;

      // ADD with preloaded operands
      wb(5'd1, 32'd5);
      wb(5'd2, 32'd7);
      drive(1'b1, 32'h100, ADD_3_1_2, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("add_valid", 32'(ex_valid), 32'h1);
      chk("add_rs", ex_rsData, 32'd5);
      chk("add_rt", ex_rtData, 32'd7);
      chk("add_alu", 32'(ex_ALUOp), 32'h20);
      chk("add_dest", 32'(ex_dest), 32'd3);
      chk("add_rw", 32'(ex_regwrite), 32'h1);

      // zero- versus sign-extended immediate
      drive(1'b1, 32'h104, ORI_4_1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("ori_imm", ex_immSXData, 32'h0000FFFF);
      drive(1'b1, 32'h108, ADDI_4_1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("addi_imm", ex_immSXData, 32'hFFFFFFFF);
      chk("addi_dest", 32'(ex_dest), 32'd4);

      // stall three cycles with a writeback to the held rs
      drive(1'b1, 32'h10c, ADD_3_1_2, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      drive(1'b1, 32'h110, ORI_4_1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("stall_ready", 32'(fd_ready), 32'h0);
      drive(1'b1, 32'h110, ORI_4_1, 1'b0, 1'b0, 1'b1, 5'd1, 32'd9);
      chk("stall_refresh", ex_rsData, 32'd9);
      drive(1'b1, 32'h110, ORI_4_1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("stall_pc", ex_pc, 32'h10c);

      // flush beats a concurrent incoming instruction; r0 write ignored
      drive(1'b1, 32'h114, ORI_4_1, 1'b1, 1'b1, 1'b1, 5'd0, 32'h1234);
      chk("flush_valid", 32'(ex_valid), 32'h0);
      drive(1'b1, 32'h118, ADD_3_0_0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("r0_rs", ex_rsData, 32'h0);

      // store decoded with a same-cycle bypassed rt
      drive(1'b1, 32'h11c, SW_2_1, 1'b1, 1'b0, 1'b1, 5'd2, 32'hDEAD);
      chk("sw_rt", ex_rtData, 32'hDEAD);
      chk("sw_rw", 32'(ex_regwrite), 32'h0);
      chk("sw_alu", 32'(ex_ALUOp), 32'h2b);

      // asynchronous reset while stalled
      drive(1'b1, 32'h120, ADD_3_1_2, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      @(negedge clock);
      ex_ready = 1'b0; fd_valid = 1'b0; wb_en = 1'b0;
      reset_n = 1'b0;
      #1;
      model_reset();
      chk_zero("midrst");
      @(posedge clock);
      #1;
      chk_zero("midrst_hold");
      @(negedge clock);
      reset_n = 1'b1;
      drive(1'b1, 32'h200, JAL_T, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("jal_dest", 32'(ex_dest), 32'd31);
      chk("jal_rw", 32'(ex_regwrite), 32'h1);
      drive(1'b1, 32'h204, ADD_3_1_2, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("cleared_rs", ex_rsData, 32'h0);

      // random traffic
      for (int n = 0; n < 600; n++) begin
         logic [31:0] ins;
         logic [5:0]  op;
         op  = OPS[$urandom_range(0, 25)];
         ins = $urandom;
         ins[31:26] = op;
         ins[25:21] = 5'($urandom_range(0, 7));
         ins[20:16] = 5'($urandom_range(0, 7));
         if (op == 6'h00 && $urandom_range(0, 3) == 0) ins[5:0] = 6'h08;
         drive($urandom_range(0, 9) < 8, $urandom, ins,
               $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0,
               $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
